// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM state codes
// and the fast/slow opcode classifier.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_MOD  = 4'h4;
    localparam logic [3:0] OP_POW  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LNOT = 4'hA;
    localparam logic [3:0] OP_LAND = 4'hB;
    localparam logic [3:0] OP_LOR  = 4'hC;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    function automatic logic is_slow(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) ||
               (op == OP_MOD) || (op == OP_POW);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// slave: arbiter side (takes requests, drives responses); master: requester side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_z;
    logic             rsp_n;
    logic             rsp_v;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  req_valid, req0_op, req0_a, req0_b,
        input  req1_op, req1_a, req1_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data,
        output rsp_z, rsp_n, rsp_v, rsp_err, busy
    );

    modport master (
        output req_valid, req0_op, req0_a, req0_b,
        output req1_op, req1_a, req1_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
        input  rsp_z, rsp_n, rsp_v, rsp_err, busy
    );

endinterface

// File: rtl/alu_exec_unit.sv
// Combinational ALU datapath shared by both requesters.
// Ports: op/a/b in; result, signed overflow v, error err out.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             v,
    output logic             err
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] pw;
    logic [WIDTH-1:0] base;

    assign sum  = a + b;
    assign diff = a - b;

    // Square-and-multiply; timed as a multicycle path.
    always_comb begin
        pw   = WIDTH'(1);
        base = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) pw = pw * base;
            base = base * base;
        end
    end

    always_comb begin
        result = '0;
        v      = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                v = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                v = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: result = a * b;
            OP_DIV: begin
                if (b == '0) begin
                    result = '1;
                    err    = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            OP_MOD: begin
                if (b == '0) begin
                    result = a;
                    err    = 1'b1;
                end else begin
                    result = a % b;
                end
            end
            OP_POW:  result = pw;
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LNOT: result = WIDTH'(a == '0);
            OP_LAND: result = WIDTH'((a != '0) && (b != '0));
            OP_LOR:  result = WIDTH'((a != '0) || (b != '0));
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter owning the shared ALU: grants one of two requesters,
// registers operands, waits the op latency, returns a tagged registered result.
// Ports: clk, rst_n (async, active-low), bus (alu_arbiter_if.slave).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SLOW_LAT = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    localparam int CW = (SLOW_LAT > 1) ? $clog2(SLOW_LAT) : 1;

    logic [1:0]       state;
    logic             last_grant;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_z_q;
    logic             rsp_n_q;
    logic             rsp_v_q;
    logic             rsp_err_q;

    logic [1:0]       grant;
    logic             take;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [WIDTH-1:0] ex_res;
    logic             ex_v;
    logic             ex_err;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign take   = |grant;
    assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant[1] ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant[1] ? bus.req1_b  : bus.req0_b;

    alu_exec_unit #(
        .WIDTH (WIDTH)
    ) u_exec (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (ex_res),
        .v      (ex_v),
        .err    (ex_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        id_q       <= grant[1];
                        last_grant <= grant[1];
                        cnt        <= is_slow(sel_op) ?
                                      CW'(SLOW_LAT - 1) : '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data_q  <= ex_res;
                        rsp_z_q     <= (ex_res == '0);
                        rsp_n_q     <= ex_res[WIDTH-1];
                        rsp_v_q     <= ex_v;
                        rsp_err_q   <= ex_err;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_n     = rsp_n_q;
    assign bus.rsp_v     = rsp_v_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit ALU datapath between two requesters, such as the decode stage and a debug/DMA port.
- Arbitrates round-robin, captures operands, and sequences fast (1-cycle) and slow (multicycle) ops.
- Computes Z/N/V/ERR flags and returns a tagged, registered result through a valid/ready response port.
- Sits between the requesters and the shared ALU; it is the only master of that ALU.

Parameters:
- WIDTH, 32: operand/result width.
- SLOW_LAT, 4: execute cycles for MUL/DIV/MOD/POW (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req0_op  in  4  requester 0 opcode.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_op  in  4  requester 1 opcode.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  WIDTH  result.
- rsp_z  out  1  result == 0.
- rsp_n  out  1  result[WIDTH-1].
- rsp_v  out  1  signed overflow, ADD/SUB only; 0 otherwise.
- rsp_err  out  1  divide-by-zero or illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 POW: unsigned, truncated to WIDTH.
  - 6 NOT (~a), 7 AND, 8 OR, 9 XOR.
  - A LNOT (!a), B LAND, C LOR: logical ops return 0 or 1 zero-extended.
  - D–F illegal.
- Slow ops: 2–5. All others are fast.
- FSM states IDLE, EXEC, RESP. Reset: state IDLE, rsp_valid 0, all rsp_* 0, last_grant = 1, counter 0.
- IDLE:
  - req_ready is combinational from req_valid and state; it is 0 outside IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On handshake, register op/a/b/id, update last_grant, load counter = (slow ? SLOW_LAT-1 : 0), then go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - At counter == 0: register result and flags, set rsp_valid, go to RESP.
  - Operand registers hold stable throughout EXEC. Slow ops are multicycle paths of SLOW_LAT.
- RESP:
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - On rsp_ready, clear rsp_valid and return to IDLE.
  - The next request is accepted no earlier than the cycle after the response handshake (no overlap).
- Latency from request handshake edge T:
  - fast op: rsp_valid high in cycle T+2.
  - slow op: rsp_valid high in cycle T+1+SLOW_LAT.
- Flags:
  - V for ADD: a[31]==b[31] && r[31]!=a[31].
  - V for SUB: a[31]!=b[31] && r[31]!=a[31].
  - Z and N are computed on the final rsp_data.
- Boundary conditions:
  - DIV or MOD with b == 0: rsp_data = all ones (DIV) or a (MOD); rsp_err = 1; Z/N follow data.
  - Illegal opcode: rsp_data = 0, rsp_err = 1, rsp_z = 1; latency as a fast op.
  - POW with b == 0: result 1.
  - A requester may drop req_valid before it is granted; no grant is then issued to it.
  - Starvation: with both requesters continuously valid, grants strictly alternate.
  - Reset mid-EXEC or mid-RESP: immediate return to reset values; the in-flight op is lost and no response is issued.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_LOR);
  - an is_slow(op) function;
  - state encodings IDLE/EXEC/RESP.
- One sub-module, alu_exec_unit: purely combinational; op, a, b in; result, v, err out.
- The arbiter instantiates alu_exec_unit once, fed from the operand registers.

Test Plan:
- Reset, then req0 ADD a=0x7FFFFFFF b=1 -> at T+2: rsp_data=0x80000000, n=1, v=1, z=0, id=0.
- Both valid every cycle, both SUB 5−5 -> grants alternate 0,1,0,1. Each response has data=0, z=1, and id matches the grant.
- req1 DIV a=100 b=0 -> rsp_valid at T+1+SLOW_LAT, data=0xFFFFFFFF, err=1. MOD a=100 b=7 -> data=2, err=0.
- req0 op=0xE -> data=0, z=1, err=1 at T+2. Next, POW a=3 b=4 -> data=81.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0, busy=1. Release -> IDLE next cycle.
- Assert rst_n=0 during EXEC of a MUL -> rsp_valid=0 and busy=0 immediately. After release, no stale response appears and req0 wins first.
